bcd_digit_streamer: RTL
=======================

# bcd_digit_streamer

Multi-digit decimal (BCD) up/down counter that serialises a snapshot of its value one 4-bit BCD digit at a time, least-significant digit first, over a valid/ready handshake. It sits directly upstream of the 4-bit BCD code converter: `digit_out[3]..digit_out[0]` drive converter inputs `a..d`. Counting and streaming are independent, so the converter always sees a coherent digit set even while the counter keeps running.

## Interface
- `NDIGITS`, default 4: number of decades. Legal range is 1..8.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `en` input, 1 bit: count enable.
- `up` input, 1 bit: 1 = increment, 0 = decrement. Sampled only when `en` is high.
- `load` input, 1 bit: synchronous load of `load_val`. Takes priority over `en`.
- `load_val` input, 4*NDIGITS bits: load value, digit 0 in bits [3:0].
- `count` output, 4*NDIGITS bits: live counter value.
- `wrap` output, 1 bit: one-cycle pulse on 9..9→0..0 (up) or 0..0→9..9 (down).
- `load_err` output, 1 bit: one-cycle pulse when any loaded nibble is greater than 9.
- `start` input, 1 bit: request a stream. Ignored while `busy` is high.
- `busy` output, 1 bit: high while in state SEND.
- `digit_valid` output, 1 bit: a digit is presented.
- `digit_ready` input, 1 bit: consumer accepts the digit.
- `digit_out` output, 4 bits: BCD digit (bit 3 = converter `a`).
- `digit_idx` output, $clog2(NDIGITS) bits (minimum 1): position of the current digit, 0 = LSD.
- `digit_last` output, 1 bit: high with the most-significant digit.

## Operation
- **Reset** (`rst_n` low, asynchronous): `count`=0, `wrap`=0, `load_err`=0. FSM returns to IDLE. `busy`, `digit_valid` and `digit_last` are 0. `digit_out`=0 and `digit_idx`=0. The snapshot register is 0.
- **Counter priority:** `load` > `en` > hold.
- **Load:** each nibble greater than 9 is replaced by 0. `load_err` pulses in the cycle after the load edge. `wrap` is not asserted on a load.
- **Increment:** decimal ripple. A decade at 9 with carry-in goes to 0 and passes carry-out to the next decade. All 9s + 1 gives 0 and pulses `wrap`.
- **Decrement:** symmetric borrow chain. All 0s − 1 gives all 9s and pulses `wrap`.
- **FSM IDLE:** when `start` is high, capture the current `count` (the pre-edge value, not the value being written this edge) into the snapshot register. Set idx=0 and go to SEND.
- **FSM SEND:** `digit_valid`=1 and `digit_out`=snapshot[idx]. `digit_last`=(idx==NDIGITS-1).
  - On `digit_valid & digit_ready`: if last, go to IDLE; otherwise idx+1.
- **Handshake rules:**
  - While `digit_valid` is high and `digit_ready` is low, `digit_out`, `digit_idx` and `digit_last` hold stable.
  - `digit_valid` never drops without a handshake except on reset.
- **`start` while busy:** no effect and no queuing.
- **Simultaneous events:**
  - `start` in the same cycle as `load`/`en`: the snapshot takes the old `count`.
  - `start` in the cycle of the final handshake is ignored, because `busy` is still high.
- **Reset mid-stream:** the stream is aborted immediately. No further digits are emitted after reset releases.

## Timing
- Counter update latency is 1 cycle: `count` reflects `load`/`en` on the following edge. `wrap` and `load_err` are registered and aligned with the new `count`.
- `start` sampled at edge T gives `digit_valid`=1 after edge T.
- With `digit_ready` held high, digit k is transferred at edge T+1+k.
- `busy` falls after edge T+NDIGITS, so the next `start` can be accepted at edge T+NDIGITS+1.
- Each low cycle of `digit_ready` adds exactly one cycle.
- All outputs are registered, with no combinational path from `digit_ready` to `digit_valid`/`digit_out`.

## Structure
- **Package `bcd_pkg`:**
  - `BCD_W`=4 and `BCD_MAX`=4'd9.
  - A 4-bit BCD digit typedef.
  - FSM state enum {IDLE, SEND}.
- **Sub-module `bcd_decade`:** one digit register with inputs load, load digit, en, up, carry-in and borrow-in, and outputs digit and carry/borrow-out. `bcd_digit_streamer` creates NDIGITS instances in a generate loop.
- The top level contains the chain, the wrap/load_err flags, the snapshot register and the FSM.

## Test plan
- **Reset defaults:** assert `rst_n` low mid-stream → all outputs are 0 immediately. After release, `busy`=0 and no `digit_valid` appears.
- **Decimal carry and wrap:** load 0x0999, `en`=1, `up`=1 for 2 cycles → `count` goes 0x1000 then 0x1001. Load 0x9999 and increment once → 0x0000 with a single `wrap` pulse. Decrement once from 0x0000 → 0x9999 with `wrap`.
- **Illegal load:** `load_val`=0x3A5F → `count`=0x3050 and `load_err` pulses for one cycle.
- **Stream with ready high:** `count`=0x4721, pulse `start` → digits 1, 2, 7, 4 on consecutive cycles, idx 0..3, `digit_last` only on 4. `busy` lasts 4 cycles.
- **Backpressure and snapshot isolation:** `start` with `count`=0x0385, then `digit_ready` low for 3 cycles on digit 1 while the counter increments each cycle.
  - Required: digit 8 held stable for those 3 cycles.
  - Required: stream is 5, 8, 3, 0 despite the counter changing.
- **Ignored start:** pulse `start` during SEND and in the final-handshake cycle → exactly one 4-digit stream. A `start` one cycle later begins a new stream.

Source files
------------

// File: rtl/bcd_digit_streamer_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg : shared BCD digit type, limits and streamer FSM states
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bcd_pkg;

  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/bcd_digit_streamer_decade.sv
// ---------------------------------------------------------------------------
// bcd_decade : one decimal digit of the up/down counter chain
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_decade
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  bcd_digit_t load_digit,
  input  logic       en,
  input  logic       up,
  input  logic       carry_in,
  input  logic       borrow_in,
  output bcd_digit_t digit,
  output logic       carry_out,
  output logic       borrow_out
);

  bcd_digit_t r_digit;
  logic       w_step;

  // Chain signals ripple regardless of en; only the step itself is gated.
  assign w_step     = en & (up ? carry_in : borrow_in);
  assign carry_out  = carry_in  & (r_digit == BCD_MAX);
  assign borrow_out = borrow_in & (r_digit == 4'd0);
  assign digit      = r_digit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digit <= '0;
    end else if (load) begin
      r_digit <= (load_digit > BCD_MAX) ? bcd_digit_t'(0) : load_digit;
    end else if (w_step) begin
      if (up)
        r_digit <= (r_digit == BCD_MAX) ? bcd_digit_t'(0) : r_digit + 4'd1;
      else
        r_digit <= (r_digit == 4'd0) ? BCD_MAX : r_digit - 4'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bcd_digit_streamer.sv
// ---------------------------------------------------------------------------
// bcd_digit_streamer : BCD up/down counter with snapshot digit streamer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_digit_streamer
  import bcd_pkg::*;
#(
  parameter  int NDIGITS = 4,
  localparam int IDX_W   = (NDIGITS > 1) ? $clog2(NDIGITS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   up,
  input  logic                   load,
  input  logic [4*NDIGITS-1:0]   load_val,
  output logic [4*NDIGITS-1:0]   count,
  output logic                   wrap,
  output logic                   load_err,
  input  logic                   start,
  output logic                   busy,
  output logic                   digit_valid,
  input  logic                   digit_ready,
  output logic [3:0]             digit_out,
  output logic [IDX_W-1:0]       digit_idx,
  output logic                   digit_last
);

  bcd_digit_t [NDIGITS-1:0] w_digits;
  logic       [NDIGITS:0]   w_carry;
  logic       [NDIGITS:0]   w_borrow;
  logic                     w_any_bad;

  logic                     r_wrap;
  logic                     r_load_err;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic       [IDX_W-1:0]   r_idx;
  logic       [IDX_W-1:0]   w_idx_nxt;
  bcd_digit_t [NDIGITS-1:0] r_snap;
  bcd_digit_t [NDIGITS-1:0] w_snap_nxt;
  bcd_digit_t               r_digit_out;
  logic                     r_last;
  logic                     w_is_last;

  assign w_carry[0]  = 1'b1;
  assign w_borrow[0] = 1'b1;

  for (genvar i = 0; i < NDIGITS; i++) begin : g_decade
    bcd_decade u_decade (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .load_digit (load_val[4*i +: 4]),
      .en         (en),
      .up         (up),
      .carry_in   (w_carry[i]),
      .borrow_in  (w_borrow[i]),
      .digit      (w_digits[i]),
      .carry_out  (w_carry[i+1]),
      .borrow_out (w_borrow[i+1])
    );
  end

  assign count = w_digits;

  always_comb begin
    w_any_bad = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (load_val[4*i +: 4] > BCD_MAX) w_any_bad = 1'b1;
    end
  end

  // A chain carry/borrow out of the top decade means every digit rolled over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_wrap     <= ~load & en & (up ? w_carry[NDIGITS] : w_borrow[NDIGITS]);
      r_load_err <= load & w_any_bad;
    end
  end

  assign wrap     = r_wrap;
  assign load_err = r_load_err;

  assign w_is_last = (r_idx == IDX_W'(NDIGITS - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_snap_nxt  = r_snap;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_snap_nxt  = w_digits;
          w_idx_nxt   = '0;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (digit_ready) begin
          if (w_is_last) begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt   = r_idx + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // Digit and last flag are precomputed from next state so they leave a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_snap      <= '0;
      r_digit_out <= '0;
      r_last      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_snap      <= w_snap_nxt;
      r_digit_out <= (w_state_nxt == SEND) ? w_snap_nxt[w_idx_nxt] : bcd_digit_t'(0);
      r_last      <= (w_state_nxt == SEND) && (w_idx_nxt == IDX_W'(NDIGITS - 1));
    end
  end

  assign busy        = (r_state == SEND);
  assign digit_valid = (r_state == SEND);
  assign digit_out   = r_digit_out;
  assign digit_idx   = r_idx;
  assign digit_last  = r_last;

endmodule

`default_nettype wire
